// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle CPU control unit: IF/ID/EXE/MEM/WB sequencer and enable decode
module multicycle_ctrl (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t r_state;

  logic w_is_add, w_is_sub, w_is_addiu, w_is_andi, w_is_ori, w_is_slt, w_is_sll;
  logic w_is_sw, w_is_lw, w_is_beq, w_is_bne, w_is_bltz;
  logic w_is_j, w_is_jr, w_is_jal, w_is_halt;
  logic w_is_rtype, w_is_imm, w_is_alu, w_is_branch, w_is_mem, w_is_nop;
  logic w_ends_in_id, w_taken;

  assign w_is_add    = (op == OP_ADD);
  assign w_is_sub    = (op == OP_SUB);
  assign w_is_addiu  = (op == OP_ADDIU);
  assign w_is_andi   = (op == OP_ANDI);
  assign w_is_ori    = (op == OP_ORI);
  assign w_is_slt    = (op == OP_SLT);
  assign w_is_sll    = (op == OP_SLL);
  assign w_is_sw     = (op == OP_SW);
  assign w_is_lw     = (op == OP_LW);
  assign w_is_beq    = (op == OP_BEQ);
  assign w_is_bne    = (op == OP_BNE);
  assign w_is_bltz   = (op == OP_BLTZ);
  assign w_is_j      = (op == OP_J);
  assign w_is_jr     = (op == OP_JR);
  assign w_is_jal    = (op == OP_JAL);
  assign w_is_halt   = (op == OP_HALT);

  assign w_is_rtype  = w_is_add | w_is_sub | w_is_slt | w_is_sll;
  assign w_is_imm    = w_is_addiu | w_is_andi | w_is_ori;
  assign w_is_alu    = w_is_rtype | w_is_imm;
  assign w_is_branch = w_is_beq | w_is_bne | w_is_bltz;
  assign w_is_mem    = w_is_sw | w_is_lw;
  assign w_is_nop    = ~(w_is_alu | w_is_branch | w_is_mem |
                         w_is_j | w_is_jr | w_is_jal | w_is_halt);
  // Jumps and unrecognised opcodes retire straight out of decode.
  assign w_ends_in_id = w_is_j | w_is_jal | w_is_jr | w_is_nop;
  assign w_taken      = (w_is_beq & zero) | (w_is_bne & ~zero) | (w_is_bltz & sign);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IF;
    end else begin
      case (r_state)
        S_IF:     r_state <= S_ID;
        S_ID: begin
          if (w_ends_in_id)     r_state <= S_IF;
          else if (w_is_halt)   r_state <= S_ID;
          else if (w_is_branch) r_state <= S_EXE_BR;
          else if (w_is_mem)    r_state <= S_EXE_LS;
          else                  r_state <= S_EXE_AL;
        end
        S_EXE_AL: r_state <= S_WB_AL;
        S_WB_AL:  r_state <= S_IF;
        S_EXE_BR: r_state <= S_IF;
        S_EXE_LS: r_state <= S_MEM;
        S_MEM:    r_state <= w_is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  r_state <= S_IF;
        default:  r_state <= S_IF;
      endcase
    end
  end

  assign state = r_state;
  assign IRWre = (r_state == S_IF);

  always_comb begin
    PCWre = 1'b0;
    PCSrc = 2'b00;
    case (r_state)
      S_ID: begin
        PCWre = w_ends_in_id;
        if (w_is_j | w_is_jal) PCSrc = 2'b11;
        else if (w_is_jr)      PCSrc = 2'b10;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = w_taken ? 2'b01 : 2'b00;
      end
      S_MEM:             PCWre = w_is_sw;
      S_WB_AL, S_WB_LD:  PCWre = 1'b1;
      default:           PCWre = 1'b0;
    endcase
  end

  assign RegWre    = (r_state == S_WB_AL) | (r_state == S_WB_LD) |
                     ((r_state == S_ID) & w_is_jal);
  assign RegDst    = w_is_jal ? 2'b10 : (w_is_rtype ? 2'b01 : 2'b00);
  assign WrRegDSrc = ~w_is_jal;

  assign mRD       = (r_state == S_MEM) & w_is_lw;
  assign mWR       = (r_state == S_MEM) & w_is_sw;
  // DBDR must capture memory data at the end of sMEM and hold it through write-back.
  assign DBDataSrc = w_is_lw & ((r_state == S_MEM) | (r_state == S_WB_LD));

  assign ALUSrcA = w_is_sll;
  assign ALUSrcB = w_is_imm | w_is_mem;
  assign ExtSel  = ~(w_is_andi | w_is_ori);

  always_comb begin
    ALUOp = 3'b000;
    if (w_is_sub | w_is_beq | w_is_bne) ALUOp = 3'b001;
    else if (w_is_andi)                 ALUOp = 3'b010;
    else if (w_is_ori)                  ALUOp = 3'b011;
    else if (w_is_slt)                  ALUOp = 3'b100;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed and randomized check of multicycle_ctrl against a per-instruction model
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, WrRegDSrc, mRD, mWR, DBDataSrc;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, PCSrc;

  multicycle_ctrl dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010,
                         ANDI = 6'b010001, ORI = 6'b010010, SLT = 6'b100110,
                         SLL = 6'b011000, SW = 6'b110000, LW = 6'b110001,
                         BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110,
                         J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  localparam int K_ALU = 0, K_BR = 1, K_SW = 2, K_LW = 3, K_JMP = 4, K_NOP = 5, K_HALT = 6;

  int tests = 0;
  int failed = 0;
  logic [5:0] known_ops [16] = '{ADD, SUB, ADDIU, ANDI, ORI, SLT, SLL, SW, LW,
                                 BEQ, BNE, BLTZ, J, JR, JAL, HALT};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h (op=%b t=%0t)", tag, obs, exp, op, $time);
    end
  endtask

  function automatic int kind(input logic [5:0] o);
    case (o)
      ADD, SUB, ADDIU, ANDI, ORI, SLT, SLL: return K_ALU;
      BEQ, BNE, BLTZ:                       return K_BR;
      SW:                                   return K_SW;
      LW:                                   return K_LW;
      J, JR, JAL:                           return K_JMP;
      HALT:                                 return K_HALT;
      default:                              return K_NOP;
    endcase
  endfunction

  function automatic int ncyc(input int k);
    case (k)
      K_ALU, K_SW: return 4;
      K_BR:        return 3;
      K_LW:        return 5;
      default:     return 2;
    endcase
  endfunction

  // State visited at step s of an instruction of class k.
  function automatic logic [2:0] exp_st(input int k, input int s);
    logic [2:0] seq_alu [4] = '{3'd0, 3'd1, 3'd6, 3'd7};
    logic [2:0] seq_br  [3] = '{3'd0, 3'd1, 3'd5};
    logic [2:0] seq_mem [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    case (k)
      K_ALU:       return seq_alu[s];
      K_BR:        return seq_br[s];
      K_SW, K_LW:  return seq_mem[s];
      default:     return (s == 0) ? 3'd0 : 3'd1;
    endcase
  endfunction

  task automatic check_step(input logic [5:0] o, input int s, input logic z, input logic sg);
    int k, n;
    bit last, rw, taken, rtype;
    logic [1:0] pcs;
    logic [2:0] aop;
    k = kind(o);
    n = ncyc(k);
    last = (s == n - 1);
    rtype = (o == ADD) || (o == SUB) || (o == SLT) || (o == SLL);
    taken = ((o == BEQ) && z) || ((o == BNE) && !z) || ((o == BLTZ) && sg);
    rw = ((o == JAL) && s == 1) || ((k == K_ALU || k == K_LW) && last);
    pcs = 2'b00;
    if (s == 1 && (o == J || o == JAL)) pcs = 2'b11;
    else if (s == 1 && o == JR)          pcs = 2'b10;
    else if (k == K_BR && s == 2 && taken) pcs = 2'b01;
    chk("state", state, exp_st(k, s));
    chk("IRWre", IRWre, s == 0);
    chk("PCWre", PCWre, last);
    chk("RegWre", RegWre, rw);
    chk("mRD", mRD, k == K_LW && s == 3);
    chk("mWR", mWR, k == K_SW && s == 3);
    chk("DBDataSrc", DBDataSrc, k == K_LW && s >= 3);
    chk("PCSrc", PCSrc, pcs);
    if (rw) begin
      chk("RegDst", RegDst, (o == JAL) ? 2'b10 : (rtype ? 2'b01 : 2'b00));
      chk("WrRegDSrc", WrRegDSrc, o != JAL);
    end
    if (s == 2 && k != K_JMP && k != K_NOP) begin
      case (o)
        SUB, BEQ, BNE: aop = 3'b001;
        ANDI:          aop = 3'b010;
        ORI:           aop = 3'b011;
        SLT:           aop = 3'b100;
        default:       aop = 3'b000;
      endcase
      chk("ALUOp", ALUOp, aop);
      chk("ALUSrcB", ALUSrcB, (o == ADDIU) || (o == ANDI) || (o == ORI) || k == K_SW || k == K_LW);
      chk("ALUSrcA", ALUSrcA, o == SLL);
      chk("ExtSel", ExtSel, !((o == ANDI) || (o == ORI)));
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic z, input logic sg, input int start);
    op = o;
    zero = z;
    sign = sg;
    for (int s = start; s < ncyc(kind(o)); s++) begin
      check_step(o, s, z, sg);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [5:0] o;
    bit found;
    Reset = 1'b1;
    op = ADD;
    zero = 1'b0;
    sign = 1'b0;
    #7;
    chk("rst_state", state, 3'd0);
    chk("rst_IRWre", IRWre, 1'b1);
    chk("rst_enables", {PCWre, RegWre, mRD, mWR, DBDataSrc, PCSrc}, 7'd0);
    Reset = 1'b0;

    // lw, branches, jal, ALU trio, unknown opcode
    run_instr(LW, 1'b0, 1'b0, 0);
    run_instr(BEQ, 1'b1, 1'b0, 0);
    run_instr(BEQ, 1'b0, 1'b0, 0);
    run_instr(BNE, 1'b0, 1'b0, 0);
    run_instr(BLTZ, 1'b0, 1'b1, 0);
    run_instr(BLTZ, 1'b1, 1'b0, 0);
    run_instr(JAL, 1'b0, 1'b0, 0);
    run_instr(JR, 1'b0, 1'b0, 0);
    run_instr(ADD, 1'b0, 1'b0, 0);
    run_instr(ADDIU, 1'b0, 1'b0, 0);
    run_instr(ORI, 1'b0, 1'b0, 0);
    run_instr(6'b101010, 1'b0, 1'b0, 0);

    // sw aborted by an async reset pulse in sMEM
    op = SW;
    for (int s = 0; s < 3; s++) begin
      check_step(SW, s, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
    end
    chk("sw_mem_mWR", mWR, 1'b1);
    Reset = 1'b1;
    #1;
    chk("abort_state", state, 3'd0);
    chk("abort_mWR", mWR, 1'b0);
    chk("abort_enables", {PCWre, RegWre, mRD, IRWre}, 4'b0001);
    #2;
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("after_abort_state", state, 3'd1);
    run_instr(SW, 1'b0, 1'b0, 1);

    // halt holds in sID until reset
    op = HALT;
    check_step(HALT, 0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(posedge CLK);
      #1;
      chk("halt_state", state, 3'd1);
      chk("halt_enables", {PCWre, RegWre, mWR, mRD}, 4'd0);
    end
    Reset = 1'b1;
    #1;
    chk("halt_rst_state", state, 3'd0);
    @(posedge CLK);
    #1;
    chk("halt_rst_hold", state, 3'd0);
    Reset = 1'b0;

    // randomized instruction stream, including unlisted opcodes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do begin
          o = 6'($urandom);
          found = 1'b0;
          for (int i = 0; i < 16; i++) if (known_ops[i] == o) found = 1'b1;
        end while (found);
      end else begin
        o = known_ops[$urandom_range(0, 14)];
      end
      run_instr(o, 1'($urandom), 1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
